// File: rtl/aes_dr_pkg.sv
// Shared constants, FSM encoding and the inverse S-box table for the dual-rail AES datapath.
package aes_dr_pkg;

  localparam int BYTE = 8;
  localparam int N    = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Byte 0x00 of the table sits in the most significant byte.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic int grp_count(int lanes);
    return (N / BYTE) / lanes;
  endfunction

  function automatic logic [7:0] inv_sbox(logic [7:0] b);
    return INV_SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/inv_sub_bytes_dual_rail_if.sv
// Upstream and downstream handshake bundle plus debug outputs of the dual-rail InvSubBytes block.
interface inv_sub_bytes_dual_rail_if
  import aes_dr_pkg::*;
;
  // Valid/ready: a transfer happens on a rising clock edge where valid and ready are both high;
  // valid, once raised, holds with stable data until that edge.
  logic         In_Valid;
  logic         In_Ready;
  logic [N-1:0] In_T;
  logic [N-1:0] In_F;
  logic         Flip_Polarity;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [N-1:0] Out_T;
  logic [N-1:0] Out_F;
  logic [1:0]   Phase;
  logic         Rail_Error;

  modport master (
    output In_Valid, In_T, In_F, Flip_Polarity, Out_Ready,
    input  In_Ready, Out_Valid, Out_T, Out_F, Phase, Rail_Error
  );

  modport slave (
    input  In_Valid, In_T, In_F, Flip_Polarity, Out_Ready,
    output In_Ready, Out_Valid, Out_T, Out_F, Phase, Rail_Error
  );

endinterface

// File: rtl/inv_sbox8b_dual_rail.sv
// Combinational dual-rail inverse S-box built as a sum of one-hot minterms per rail.
module inv_sbox8b_dual_rail
  import aes_dr_pkg::*;
(
  input  logic [7:0] i_t,
  input  logic [7:0] i_f,
  output logic [7:0] o_t,
  output logic [7:0] o_f
);

  // A minterm fires only when every bit selects an asserted rail, so an all-0 spacer
  // fires nothing and an all-1 spacer fires everything: spacer polarity is preserved.
  always_comb begin
    logic [7:0] val;
    logic       hit;
    o_t = '0;
    o_f = '0;
    val = '0;
    hit = 1'b0;
    for (int v = 0; v < 256; v++) begin
      val = 8'(v);
      hit = 1'b1;
      for (int i = 0; i < 8; i++) begin
        hit = hit & (val[i] ? i_t[i] : i_f[i]);
      end
      if (hit) begin
        o_t = o_t | inv_sbox(val);
        o_f = o_f | ~inv_sbox(val);
      end
    end
  end

endmodule

// File: rtl/inv_sub_bytes_dual_rail.sv
// Dual-rail inverse SubBytes: LANES shared S-boxes, a spacer cycle before every group evaluation.
module inv_sub_bytes_dual_rail
  import aes_dr_pkg::*;
#(
  parameter int LANES = 4
) (
  input logic                      Clk,
  input logic                      Reset,
  inv_sub_bytes_dual_rail_if.slave bus
);

  localparam int G     = grp_count(LANES);
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int GRP_W = LANES * BYTE;

  localparam logic [1:0]    S_IDLE = ST_IDLE;
  localparam logic [1:0]    S_PRE  = ST_PRE;
  localparam logic [1:0]    S_EVAL = ST_EVAL;
  localparam logic [1:0]    S_DONE = ST_DONE;
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  logic [1:0]       r_state;
  logic [GW-1:0]    r_g;
  logic [N-1:0]     r_in_t;
  logic [N-1:0]     r_in_f;
  logic             r_flip;
  logic [N-1:0]     r_out_t;
  logic [N-1:0]     r_out_f;
  logic             r_out_valid;
  logic             r_rail_err;

  logic             w_accept;
  logic             w_eval;
  logic [GRP_W-1:0] w_grp_t;
  logic [GRP_W-1:0] w_grp_f;
  logic [GRP_W-1:0] w_sb_in_t;
  logic [GRP_W-1:0] w_sb_in_f;
  logic [GRP_W-1:0] w_sb_out_t;
  logic [GRP_W-1:0] w_sb_out_f;

  assign w_accept = (r_state == S_IDLE) && bus.In_Valid;
  assign w_eval   = (r_state == S_EVAL);

  always_comb begin
    w_grp_t = '0;
    w_grp_f = '0;
    for (int gi = 0; gi < G; gi++) begin
      if (r_g == GW'(gi)) begin
        w_grp_t = r_in_t[gi*GRP_W +: GRP_W];
        w_grp_f = r_in_f[gi*GRP_W +: GRP_W];
      end
    end
  end

  // Outside EVAL the lanes rest at the spacer, so each rail net toggles once per evaluation.
  assign w_sb_in_t = w_eval ? w_grp_t : {GRP_W{r_flip}};
  assign w_sb_in_f = w_eval ? w_grp_f : {GRP_W{r_flip}};

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      inv_sbox8b_dual_rail u_sbox (
        .i_t (w_sb_in_t[l*BYTE +: BYTE]),
        .i_f (w_sb_in_f[l*BYTE +: BYTE]),
        .o_t (w_sb_out_t[l*BYTE +: BYTE]),
        .o_f (w_sb_out_f[l*BYTE +: BYTE])
      );
    end
  endgenerate

  // Input registers are left holding stale data after use; outputs only move in EVAL.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_in_t <= bus.In_T;
      r_in_f <= bus.In_F;
      r_flip <= bus.Flip_Polarity;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_g         <= '0;
      r_out_t     <= '0;
      r_out_f     <= '0;
      r_out_valid <= 1'b0;
      r_rail_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rail_err <= 1'b0;
            r_g        <= '0;
            r_state    <= S_PRE;
          end
        end
        S_PRE: begin
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          for (int gi = 0; gi < G; gi++) begin
            if (r_g == GW'(gi)) begin
              r_out_t[gi*GRP_W +: GRP_W] <= w_sb_out_t;
              r_out_f[gi*GRP_W +: GRP_W] <= w_sb_out_f;
            end
          end
          if (|(~(w_sb_out_t ^ w_sb_out_f))) begin
            r_rail_err <= 1'b1;
          end
          if (r_g == G_LAST) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_g     <= r_g + GW'(1);
            r_state <= S_PRE;
          end
        end
        S_DONE: begin
          if (bus.Out_Ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.In_Ready   = (r_state == S_IDLE);
  assign bus.Out_Valid  = r_out_valid;
  assign bus.Out_T      = r_out_t;
  assign bus.Out_F      = r_out_f;
  assign bus.Phase      = r_state;
  assign bus.Rail_Error = r_rail_err;

endmodule
